// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key scheduler: loaded with the round-10 key, emits round keys 10..0
// one per accepted beat by undoing the forward KeyExpansion step.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform.
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, in_byte);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [0:127] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [0:127] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word, sub_word;
  logic [7:0]   rcon;
  logic [0:127] prev_key;

  assign w0 = rk_q[0:31];
  assign w1 = rk_q[32:63];
  assign w2 = rk_q[64:95];
  assign w3 = rk_q[96:127];

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot_word = {p3[23:0], p3[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (rot_word[8*g +: 8]),
        .out_byte (sub_word[8*g +: 8])
      );
    end
  endgenerate

  // Rcon of the round being undone, i.e. the round currently on rk_out.
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0       = w0 ^ sub_word ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = last_key;
          round_d = 4'(NR);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_d    = prev_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == EMIT);
  assign rk_valid = (state_q == EMIT);
  assign rk_out   = rk_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule
